carry_save_resolver: RTL and testbench
======================================

CARRY_SAVE_RESOLVER -- requirements
Module: carry_save_resolver

Interface
REQ-001 Parameter WIDTH, default 16; operand width in bits; SHALL be a multiple of SLICE, otherwise an elaboration error.
REQ-002 Parameter SLICE, default 4; bits resolved per clock cycle.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  carry-save pair presented.
REQ-006 in_ready  output  1  block accepts a pair this cycle.
REQ-007 in_sum  input  WIDTH  partial-sum vector.
REQ-008 in_carry  input  WIDTH  carry vector, pre-aligned to sum bit weights.
REQ-009 out_valid  output  1  resolved result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_result  output  WIDTH+1  binary value in_sum+in_carry.
REQ-012 busy  output  1  high in RESOLVE state.

Function
REQ-013 FSM SHALL have three states: IDLE, RESOLVE, DONE.
REQ-014 Accept condition: in_valid && in_ready; operands are captured into internal registers on that edge.
REQ-015 in_ready SHALL be 1 in IDLE, equal to out_ready in DONE, and 0 in RESOLVE.
REQ-016 IDLE -> RESOLVE on accept; slice counter cleared; carry-in cleared to 0.
REQ-017 RESOLVE: each cycle add slice k of sum, carry and the stored carry-in; write SLICE result bits; store the slice carry-out; increment k.
REQ-018 RESOLVE -> DONE after WIDTH/SLICE cycles; out_result[WIDTH] = final carry-out.
REQ-019 Latency: out_valid SHALL assert exactly WIDTH/SLICE+1 cycles after the accept edge (5 for the default parameters).
REQ-020 DONE: out_valid=1; out_result stable until out_valid && out_ready.
REQ-021 DONE and out_ready with no accept -> IDLE; out_valid drops next cycle.
REQ-022 DONE and out_ready and in_valid (simultaneous handshakes) -> RESOLVE with the new operands, giving zero-bubble back-to-back operation.
REQ-023 Slice counter SHALL wrap to 0 on leaving RESOLVE; no state other than the three listed is reachable.
REQ-024 in_sum and in_carry changes while not accepting SHALL NOT affect the result.
REQ-025 Arithmetic is unsigned modulo 2^(WIDTH+1); no truncation of the MSB carry.

Reset
REQ-026 While rst_n=0: state=IDLE, out_valid=0, busy=0, out_result=0, internal operand, carry and counter registers = 0.
REQ-027 in_ready SHALL be 1 during and after reset (IDLE).
REQ-028 Reset asserted mid-RESOLVE or mid-DONE SHALL abort the operation; no result is emitted after release.

Configuration
REQ-029 Macro CSR_SIGNED_OVF_EN.
REQ-030 Defined: extra output port out_ovf (1 bit) = two's-complement overflow of the WIDTH-bit sum, i.e. (sum MSB == carry MSB) && (result[WIDTH-1] != sum MSB). Valid with out_valid; reset 0; held with out_result.
REQ-031 Undefined: port out_ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package csr_pkg SHALL hold the state enum typedef (IDLE/RESOLVE/DONE) and the default WIDTH and SLICE constants.
REQ-033 One sub-module csr_slice: a combinational SLICE-bit ripple adder (a, b, cin -> sum, cout) built from the existing full_adder; instantiated once and time-multiplexed across slices.

Verification (WIDTH=16, SLICE=4)
REQ-034 sum=0xFFFF, carry=0x0001, out_ready=1 -> out_valid 5 cycles after accept, out_result=0x10000.
REQ-035 sum=0x1234, carry=0x4321, out_ready held 0 for 10 cycles -> out_result=0x05555 held stable and in_ready=0 until out_ready=1, then IDLE.
REQ-036 Back-to-back: first result, then sum=0x00FF/carry=0x0F01 presented with in_valid=1 and out_ready=1 in DONE -> both handshakes in the same cycle; second result 0x1000 after 5 cycles.
REQ-037 rst_n pulsed low 2 cycles after accepting 0xAAAA/0x5555 -> outputs zero, out_valid never asserts, next op 0x0001/0x0001 -> 0x00002.
REQ-038 CSR_SIGNED_OVF_EN defined: 0x7FFF+0x0001 -> out_result=0x08000, out_ovf=1; 0xFFFF+0x0001 -> 0x10000, out_ovf=0.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared state encoding and default geometry for carry_save_resolver
package csr_pkg;
  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;
endpackage

// File: rtl/csr_slice.sv
// csr_slice: combinational W-bit ripple adder built from full_adder cells
// ports: a, b operands; cin carry in; sum W-bit result; cout carry out
module csr_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  assign cout = c[W];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder
// ports: a, b, ci in; s sum out; co carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/carry_save_resolver.sv
// carry_save_resolver: resolves a carry-save pair into binary, SLICE bits per clock
// ports: clk, rst_n (async active-low); in_valid/in_ready/in_sum/in_carry input handshake;
//        out_valid/out_ready/out_result output handshake; busy high while resolving;
//        out_ovf signed overflow flag, present only when CSR_SIGNED_OVF_EN is defined
module carry_save_resolver
  import csr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
`ifdef CSR_SIGNED_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH:0] SMASK = {{(WIDTH + 1 - SLICE){1'b0}}, {SLICE{1'b1}}};
  if (WIDTH % SLICE != 0) begin : g_bad_geometry
    $error("carry_save_resolver: WIDTH must be a multiple of SLICE");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, vld_q, vld_d;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, accept, last;
  int               sh;
  assign in_ready   = state_q == IDLE ? 1'b1 : state_q == DONE ? out_ready : 1'b0;
  assign accept     = in_valid && in_ready;
  assign last       = cnt_q == CW'(N);
  assign busy       = state_q == RESOLVE;
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign sh         = SLICE * int'(cnt_q);
  assign sl_a       = SLICE'(a_q >> sh);
  assign sl_b       = SLICE'(b_q >> sh);
  csr_slice #(.W(SLICE)) u_slice (.a(sl_a), .b(sl_b), .cin(c_q), .sum(sl_s), .cout(sl_co));
  // RESOLVE spends one extra cycle after the last slice to fold the final
  // carry into the MSB, which places out_valid WIDTH/SLICE+1 cycles after accept.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = vld_q;
    if (accept) begin
      a_d     = in_sum;
      b_d     = in_carry;
      c_d     = 1'b0;
      cnt_d   = '0;
      vld_d   = 1'b0;
      state_d = RESOLVE;
    end else if (state_q == RESOLVE && last) begin
      res_d[WIDTH] = c_q;
      cnt_d        = '0;
      vld_d        = 1'b1;
      state_d      = DONE;
    end else if (state_q == RESOLVE) begin
      res_d = (res_q & ~(SMASK << sh)) | ((WIDTH + 1)'(sl_s) << sh);
      c_d   = sl_co;
      cnt_d = cnt_q + CW'(1);
    end else if (state_q == DONE && out_ready) begin
      vld_d   = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end
`ifdef CSR_SIGNED_OVF_EN
  logic ovf_q, ovf_d;
  // res_q[WIDTH-1] is already final on the carry-fold cycle
  always_comb ovf_d = (state_q == RESOLVE && last) ?
                      ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1])) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign out_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_carry_save_resolver.sv
// tb_carry_save_resolver: scoreboard bench with random stimulus for carry_save_resolver
module tb_carry_save_resolver;
  localparam int W = 16;
  typedef struct {logic [W:0] res; logic ovf; int cyc;} exp_t;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_sum = '0, in_carry = '0;
  logic         in_ready, out_valid, busy;
  logic [W:0]   out_result;
`ifdef CSR_SIGNED_OVF_EN
  logic         out_ovf;
`endif
  exp_t q[$];
  int   compared = 0, mismatched = 0, cyc = 0;
  bit   rnd_rdy = 0, b2b_seen = 0, seen = 0;

  always #5 clk = ~clk;

  carry_save_resolver #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result),
`ifdef CSR_SIGNED_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy));

  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c, input int cy);
    exp_t e;
    e.res = {1'b0, s} + {1'b0, c};
    e.ovf = (s[W-1] == c[W-1]) && (e.res[W-1] != s[W-1]);
    e.cyc = cy;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) q.delete();
    else if (in_valid && in_ready) begin
      if (out_valid && out_ready) b2b_seen = 1;
      q.push_back(model(in_sum, in_carry, cyc));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got %0h expected no output", out_result);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 32'(cyc - q[0].cyc), 32'd5);
        end
        check("result", 32'(out_result), 32'(q[0].res));
`ifdef CSR_SIGNED_OVF_EN
        check("ovf", 32'(out_ovf), 32'(q[0].ovf));
`endif
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    bit acc = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) timeout("accept");
    in_valid = 1'b0;
    in_sum   = W'($urandom);
    in_carry = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) tick();
    if (q.size() != 0) timeout("drain");
  endtask

  initial begin
    int bad;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001);
    check("busy_resolve", 32'(busy), 32'd1);
    check("in_ready_resolve", 32'(in_ready), 32'd0);
    drain();
    out_ready = 1'b0;
    send(16'h1234, 16'h4321);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    if (!out_valid) timeout("wait_valid");
    for (int i = 0; i < 10; i++) begin
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("post_take_valid", 32'(out_valid), 32'd0);
    check("post_take_in_ready", 32'(in_ready), 32'd1);
    b2b_seen = 0;
    send(16'h0F0F, 16'h00F1);
    send(16'h00FF, 16'h0F01);
    check("b2b_same_cycle", 32'(b2b_seen), 32'd1);
    drain();
    send(16'hAAAA, 16'h5555);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(out_result), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) bad++;
    end
    check("no_output_after_abort", 32'(bad), 32'd0);
    send(16'h0001, 16'h0001);
    drain();
    send(16'h7FFF, 16'h0001);
    send(16'hFFFF, 16'h0001);
    send(16'h0000, 16'h0000);
    send(16'hFFFF, 16'hFFFF);
    send(16'h8000, 16'h8000);
    drain();
    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), W'($urandom));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
